// File: rtl/div_pkg.sv
// Shared encodings for the sequential divider: funct codes and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    // funct encodings; bit 0 set = unsigned, bit 1 set = remainder
    localparam logic [1:0] FN_DIV  = 2'b00;
    localparam logic [1:0] FN_DIVU = 2'b01;
    localparam logic [1:0] FN_REM  = 2'b10;
    localparam logic [1:0] FN_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_t;

    // Iteration counter width: must hold the values 0..WIDTH inclusive
    function automatic int iter_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in next dividend bit, trial subtract, select.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
// Ports: rem/quo/dvs = current partial remainder, quotient/dividend shifter, divisor;
//        rem_nxt/quo_nxt = state after this step.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0]   sh;
    logic             borrow;
    logic [WIDTH-1:0] diff;

    always_comb begin
        // The shifted remainder needs WIDTH+1 bits: with a divisor above 2^(WIDTH-1)
        // the partial remainder can exceed WIDTH bits once shifted.
        sh      = {rem, quo[WIDTH-1]};
        borrow  = (sh < {1'b0, dvs});
        // When there is no borrow the true difference is below dvs, so the low
        // WIDTH bits of the subtraction are exact.
        diff    = sh[WIDTH-1:0] - dvs;
        rem_nxt = borrow ? sh[WIDTH-1:0] : diff;
        quo_nxt = {quo[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/seq_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU (quotient or remainder, signed or not).
// Latency: start accepted at edge k, done pulses after edge k+WIDTH+2 (k+2 for special cases
//          when DIV_FAST_SPECIAL_EN is defined: divide-by-zero and MIN/-1 skip the iterations).
// Backpressure: one op at a time; En is ignored while busy and during the done cycle.
// Ports: CLK, rst (async active-high); En/funct/rs_1/rs_2 start an op;
//        result/div_by_zero hold until overwritten by the next op; busy; done (1-cycle pulse).
module seq_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             En,
    input  logic [1:0]       funct,
    input  logic [WIDTH-1:0] rs_1,
    input  logic [WIDTH-1:0] rs_2,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int             IW        = iter_width(WIDTH);
    localparam logic [IW-1:0]  ITER_LAST = IW'(WIDTH);

    div_state_t       state, state_nxt;
    logic [WIDTH-1:0] q_r, rem_r, dvs_r;
    logic [IW-1:0]    iter_r;
    logic [1:0]       fn_r;
    logic             neg_q_r, neg_r_r, dz_r;

    logic             start;
    logic             in_signed, a_neg, b_neg, in_dz;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] rem_step, quo_step;

    logic [WIDTH-1:0] q_fix, r_fix, res_nxt;
    logic             busy_nxt, fix_now;

    // The done cycle is excluded so a start request there cannot chain straight into a new op
    assign start     = (state == ST_IDLE) && En && !done;

    assign in_signed = ~funct[0];
    assign a_neg     = in_signed & rs_1[WIDTH-1];
    assign b_neg     = in_signed & rs_2[WIDTH-1];
    // Abs of MIN wraps back to MIN, which is the correct unsigned magnitude
    assign a_abs     = a_neg ? (-rs_1) : rs_1;
    assign b_abs     = b_neg ? (-rs_2) : rs_2;
    assign in_dz     = (rs_2 == '0);

`ifdef DIV_FAST_SPECIAL_EN
    logic in_ovf, in_skip;
    assign in_ovf  = in_signed && (rs_1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs_2 == '1);
    assign in_skip = in_dz | in_ovf;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_r),
        .quo     (q_r),
        .dvs     (dvs_r),
        .rem_nxt (rem_step),
        .quo_nxt (quo_step)
    );

    // State register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. CALC spends one extra cycle at iter==WIDTH before FIX.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CALC;
            ST_CALC: if (iter_r == ITER_LAST) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand load and iteration
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            q_r     <= '0;
            rem_r   <= '0;
            dvs_r   <= '0;
            iter_r  <= '0;
            fn_r    <= FN_DIV;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            dz_r    <= 1'b0;
        end else if (start) begin
            fn_r    <= funct;
            neg_q_r <= a_neg ^ b_neg;
            neg_r_r <= a_neg;
            dz_r    <= in_dz;
            dvs_r   <= b_abs;
            q_r     <= a_abs;
            rem_r   <= '0;
            iter_r  <= '0;
`ifdef DIV_FAST_SPECIAL_EN
            // Preload the final state: MIN/-1 already has q=|MIN|, rem=0; x/0 ends
            // with rem=|a| and a forced all-ones quotient.
            if (in_skip) iter_r <= ITER_LAST;
            if (in_dz)   rem_r  <= a_abs;
`endif
        end else if (state == ST_CALC && iter_r != ITER_LAST) begin
            q_r    <= quo_step;
            rem_r  <= rem_step;
            iter_r <= iter_r + IW'(1);
        end
    end

    // Output logic: sign correction and result select
    always_comb begin
        q_fix    = dz_r ? '1 : (neg_q_r ? (-q_r) : q_r);
        r_fix    = neg_r_r ? (-rem_r) : rem_r;
        res_nxt  = fn_r[1] ? r_fix : q_fix;
        fix_now  = (state == ST_FIX);
        busy_nxt = (state != ST_IDLE) && (state_nxt != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            result      <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= fix_now;
            if (fix_now) begin
                result      <= res_nxt;
                div_by_zero <= dz_r;
            end
        end
    end

endmodule
